// File: rtl/ifu_ift2axi_pkg.sv
// Shared types and constants for the IFU fetch-to-AXI4-Lite bridge.
// Widths, bus response/protection codes and FSM state encodings.
package ifu_ift2axi_pkg;

  localparam int PC_SIZE    = 32;
  localparam int INSTR_SIZE = 32;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } ift_state_e;

endpackage

// File: rtl/ifu_ift2axi.sv
// Fetch-bus bridge: one buffered pc request issued as an AXI4-Lite read.
// One AR/R in flight; instruction and error returned on the rsp channel.
module ifu_ift2axi
  import ifu_ift2axi_pkg::*;
#(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_rsp_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [AXI_AW-1:0]     axi_araddr,
  output logic [2:0]            axi_arprot,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [AXI_DW-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp
);

  localparam int LSB = $clog2(AXI_DW / 8);

  ift_state_e            state;
  logic                  req_vld;
  logic [PC_SIZE-1:0]    req_pc;
  logic                  lane;
  logic                  mis;
  logic                  drop;
  logic                  req_hsk;
  logic                  ar_hsk;
  logic [63:0]           rdata_w;
  logic [INSTR_SIZE-1:0] lane_word;

  assign mis     = |req_pc[1:0];
  assign drop    = (state == ST_IDLE) & req_vld & mis;
  assign req_hsk = ifu_req_valid & ifu_req_ready;
  assign ar_hsk  = axi_arvalid & axi_arready;

  // Ready depends only on the buffer so the fetch stage may gate
  // rsp_ready with it without forming a combinational loop.
  assign ifu_req_ready = ~req_vld;

  assign axi_arvalid = (state == ST_IDLE) & req_vld & ~mis;
  assign axi_araddr  = {req_pc[AXI_AW-1:LSB], {LSB{1'b0}}};
  assign axi_arprot  = AXI_PROT_INSTR;
  assign axi_rready  = (state == ST_DATA);

  assign ifu_rsp_valid = (state == ST_RESP);

  assign rdata_w   = 64'(axi_rdata);
  assign lane_word = lane ? rdata_w[63:32] : rdata_w[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else if (req_hsk) begin
      req_vld <= 1'b1;
      req_pc  <= ifu_req_pc;
    end else if (ar_hsk | drop) begin
      req_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lane          <= 1'b0;
      ifu_rsp_instr <= '0;
      ifu_rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (drop) begin
            state         <= ST_RESP;
            ifu_rsp_instr <= '0;
            ifu_rsp_err   <= 1'b1;
          end else if (ar_hsk) begin
            state <= ST_DATA;
            lane  <= (AXI_DW == 64) && req_pc[2];
          end
        end
        ST_DATA: begin
          if (axi_rvalid) begin
            state         <= ST_RESP;
            ifu_rsp_instr <= lane_word;
            ifu_rsp_err   <= (axi_rresp != AXI_RESP_OKAY);
          end
        end
        ST_RESP: begin
          if (ifu_rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_ift2axi.sv
// Scoreboard bench for ifu_ift2axi: 32-bit bus instance plus a 64-bit
// bus instance for lane selection.
module tb_ifu_ift2axi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc = '0;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  logic        req2_valid = 1'b0;
  logic        req2_ready;
  logic [31:0] req2_pc = '0;
  logic        rsp2_valid;
  logic        rsp2_ready = 1'b1;
  logic [31:0] rsp2_instr;
  logic        rsp2_err;
  logic        arvalid2;
  logic        arready2 = 1'b0;
  logic [31:0] araddr2;
  logic [2:0]  arprot2;
  logic        rvalid2 = 1'b0;
  logic        rready2;
  logic [63:0] rdata2 = '0;
  logic [1:0]  rresp2 = 2'b00;

  ifu_ift2axi #(.AXI_DW(32), .AXI_AW(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  ifu_ift2axi #(.AXI_DW(64), .AXI_AW(32)) dut64 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(req2_valid), .ifu_req_ready(req2_ready),
    .ifu_req_pc(req2_pc),
    .ifu_rsp_valid(rsp2_valid), .ifu_rsp_ready(rsp2_ready),
    .ifu_rsp_instr(rsp2_instr), .ifu_rsp_err(rsp2_err),
    .axi_arvalid(arvalid2), .axi_arready(arready2),
    .axi_araddr(araddr2), .axi_arprot(arprot2),
    .axi_rvalid(rvalid2), .axi_rready(rready2),
    .axi_rdata(rdata2), .axi_rresp(rresp2)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [33:0] slv_q[$];
  logic [32:0] exp2_q[$];

  int ar_stall = 0;
  int rsp_stall = 0;
  int r_delay = 0;
  int ar_count = 0;
  int r_cnt = -1;
  logic [33:0] pend = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // AXI slave for the 32-bit instance; drives on the falling edge.
  initial begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      axi_rvalid  = 1'b0;
      axi_arready = 1'b0;
      if (rst) begin
        r_cnt = -1;
        continue;
      end
      if (r_cnt == 0) begin
        chk("rready in data", 64'(axi_rready), 64'd1);
        axi_rvalid = 1'b1;
        {axi_rresp, axi_rdata} = pend;
        r_cnt = -1;
      end else if (r_cnt > 0) begin
        r_cnt--;
      end
      if (axi_arvalid) begin
        if (exp_ar_q.size() == 0) begin
          chk("unexpected arvalid", 64'(axi_arvalid), 64'd0);
        end else if (ar_stall > 0) begin
          chk("araddr stable", 64'(axi_araddr), 64'(exp_ar_q[0]));
          ar_stall--;
        end else begin
          axi_arready = 1'b1;
          chk("araddr", 64'(axi_araddr), 64'(exp_ar_q.pop_front()));
          chk("arprot", 64'(axi_arprot), 64'd4);
          ar_count++;
          pend  = slv_q.pop_front();
          r_cnt = r_delay;
        end
      end
    end
  end

  // Response monitor for the 32-bit instance.
  initial begin
    logic [32:0] e;
    ifu_rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      ifu_rsp_ready = 1'b1;
      if (!rst && ifu_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected rsp", 64'(ifu_rsp_valid), 64'd0);
        end else if (rsp_stall > 0) begin
          ifu_rsp_ready = 1'b0;
          rsp_stall--;
          chk("rsp held", 64'({ifu_rsp_err, ifu_rsp_instr}), 64'(exp_q[0]));
        end else begin
          e = exp_q.pop_front();
          chk("rsp instr", 64'(ifu_rsp_instr), 64'(e[31:0]));
          chk("rsp err", 64'(ifu_rsp_err), 64'(e[32]));
        end
      end
    end
  end

  // Response monitor for the 64-bit instance.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp2_valid) begin
        if (exp2_q.size() == 0) begin
          chk("dw64 unexpected rsp", 64'(rsp2_valid), 64'd0);
        end else begin
          e = exp2_q.pop_front();
          chk("dw64 instr", 64'(rsp2_instr), 64'(e[31:0]));
          chk("dw64 err", 64'(rsp2_err), 64'(e[32]));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic bus,
                       input logic [31:0] ea, input logic [31:0] rdata,
                       input logic [1:0] rresp, input logic [31:0] ei,
                       input logic ee);
    if (bus) begin
      exp_ar_q.push_back(ea);
      slv_q.push_back({rresp, rdata});
    end
    exp_q.push_back({ee, ei});
    ifu_req_valid = 1'b1;
    ifu_req_pc    = pc;
    @(negedge clk);
    ifu_req_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ifu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifu_req_ready) chk("req_ready timeout", 64'(ifu_req_ready), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fetch64(input logic [31:0] pc, input logic [31:0] ea,
                         input logic [63:0] rd, input logic [31:0] ei);
    int n = 0;
    exp2_q.push_back({1'b0, ei});
    req2_valid = 1'b1;
    req2_pc    = pc;
    @(negedge clk);
    req2_valid = 1'b0;
    while (!arvalid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dw64 arvalid", 64'(arvalid2), 64'd1);
    chk("dw64 araddr", 64'(araddr2), 64'(ea));
    arready2 = 1'b1;
    @(negedge clk);
    arready2 = 1'b0;
    chk("dw64 rready", 64'(rready2), 64'd1);
    rvalid2 = 1'b1;
    rdata2  = rd;
    @(negedge clk);
    rvalid2 = 1'b0;
    rdata2  = '0;
    n = 0;
    while (exp2_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dw64 drain", 64'(exp2_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    @(negedge clk);
    chk("reset req_ready", 64'(ifu_req_ready), 64'd1);
    chk("reset rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("reset arvalid", 64'(axi_arvalid), 64'd0);
    chk("reset araddr", 64'(axi_araddr), 64'd0);
    chk("reset rready", 64'(axi_rready), 64'd0);
    chk("reset instr", 64'(ifu_rsp_instr), 64'd0);
    chk("reset err", 64'(ifu_rsp_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single fetch and best-case latency
    wait_ready();
    issue(32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0000_0413, 2'b00,
          32'h0000_0413, 1'b0);
    n = 1;
    while (!ifu_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    drain();

    // AR and rsp back-pressure
    ar_stall  = 5;
    rsp_stall = 3;
    wait_ready();
    issue(32'h8000_0008, 1'b1, 32'h8000_0008, 32'h0011_0113, 2'b00,
          32'h0011_0113, 1'b0);
    drain();
    chk("ar stall consumed", 64'(ar_stall), 64'd0);
    chk("rsp stall consumed", 64'(rsp_stall), 64'd0);

    // back-to-back: next request in the rsp handshake cycle
    wait_ready();
    issue(32'h8000_0010, 1'b1, 32'h8000_0010, 32'h0041_0413, 2'b00,
          32'h0041_0413, 1'b0);
    n = 0;
    while (!ifu_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b req_ready", 64'(ifu_req_ready), 64'd1);
    issue(32'h8000_0004, 1'b1, 32'h8000_0004, 32'h0081_0813, 2'b00,
          32'h0081_0813, 1'b0);
    chk("b2b arvalid", 64'(axi_arvalid), 64'd1);
    chk("b2b araddr", 64'(axi_araddr), 64'h8000_0004);
    drain();

    // misaligned pc, then a bus error
    wait_ready();
    issue(32'h8000_0002, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1);
    drain();
    wait_ready();
    issue(32'h8000_0014, 1'b1, 32'h8000_0014, 32'hdead_beef, 2'b10,
          32'hdead_beef, 1'b1);
    drain();

    // 64-bit bus lane selection
    fetch64(32'h8000_0004, 32'h8000_0000, 64'h1111_1111_2222_2222,
            32'h1111_1111);
    fetch64(32'h8000_0000, 32'h8000_0000, 64'h1111_1111_2222_2222,
            32'h2222_2222);

    // reset while waiting for R data
    r_delay = 3;
    wait_ready();
    issue(32'h8000_0000, 1'b1, 32'h8000_0000, 32'hbad0_0bad, 2'b00,
          32'hbad0_0bad, 1'b0);
    n = 0;
    while (!axi_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached data", 64'(axi_rready), 64'd1);
    rst = 1'b1;
    #1;
    chk("async req_ready", 64'(ifu_req_ready), 64'd1);
    chk("async rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("async arvalid", 64'(axi_arvalid), 64'd0);
    chk("async araddr", 64'(axi_araddr), 64'd0);
    chk("async rready", 64'(axi_rready), 64'd0);
    chk("async instr", 64'(ifu_rsp_instr), 64'd0);
    chk("async err", 64'(ifu_rsp_err), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    r_delay = 0;
    @(negedge clk);
    wait_ready();
    issue(32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0000_0013, 2'b00,
          32'h0000_0013, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    chk("ar count", 64'(ar_count), 64'd7);
    chk("ar queue empty", 64'(exp_ar_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
